// File: rtl/control_pipeline.sv
// control_pipeline: ID-stage control decode, the ID/EX -> EX/MEM -> MEM/WB
// control-word registers, and the hazard logic that stalls or flushes the
// front end. Load-use hazards, multi-cycle muldiv occupancy and EX-stage
// redirects are handled here.
//
// Control word layout, MSB first:
//   {muldiv, jalr_jump, regwrite_sel[1:0], regwrite, alusrc, memwrite,
//    aluop[2:0], memtoreg, memread, branch, valid}
// A bubble is the all-zero word with rd = 0. Any word with valid = 0 also
// carries rd = 0, so downstream forwarding never matches a non-instruction.
//
// Muldiv timing: a muldiv occupies EX for exactly MD_LATENCY cycles. The
// ID/EX register is held for the first MD_LATENCY-1 of them; on the last one
// the instruction leaves EX and the next one enters behind it.
module control_pipeline #(
  parameter int ENABLE_M   = 1,
  parameter int MD_LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  id_opcode,
  input  logic        id_funct7_0,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic [4:0]  id_rd,
  input  logic        ex_redirect,
  output logic        stall_id,
  output logic        flush_id,
  output logic        md_start,
  output logic [13:0] ex_ctrl,
  output logic [13:0] mem_ctrl,
  output logic [13:0] wb_ctrl,
  output logic [4:0]  ex_rd,
  output logic [4:0]  mem_rd,
  output logic [4:0]  wb_rd
);

  // Opcode bits [6:2] of the RV32I base encodings
  localparam logic [4:0] OPCODE_R      = 5'b01100;
  localparam logic [4:0] OPCODE_I      = 5'b00100;
  localparam logic [4:0] OPCODE_LOAD   = 5'b00000;
  localparam logic [4:0] OPCODE_STORE  = 5'b01000;
  localparam logic [4:0] OPCODE_BRANCH = 5'b11000;
  localparam logic [4:0] OPCODE_JALR   = 5'b11001;
  localparam logic [4:0] OPCODE_JAL    = 5'b11011;
  localparam logic [4:0] OPCODE_LUI    = 5'b01101;
  localparam logic [4:0] OPCODE_AUIPC  = 5'b00101;

  // ALU operation classes consumed by the EX-stage ALU control
  localparam logic [2:0] ALUOP_LOAD_STORE = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH     = 3'b001;
  localparam logic [2:0] ALUOP_R_I        = 3'b010;
  localparam logic [2:0] ALUOP_JALR       = 3'b011;
  localparam logic [2:0] ALUOP_OTHER      = 3'b100;

  typedef struct packed {
    logic       muldiv;
    logic       jalr_jump;
    logic [1:0] regwrite_sel;
    logic       regwrite;
    logic       alusrc;
    logic       memwrite;
    logic [2:0] aluop;
    logic       memtoreg;
    logic       memread;
    logic       branch;
    logic       valid;
  } ctrl_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_t;

  ctrl_t      id_word;
  logic [4:0] id_rd_eff;
  ctrl_t      ex_q, mem_q, wb_q;
  logic [4:0] ex_rd_q, mem_rd_q, wb_rd_q;

  md_state_t  state_q, state_d;
  logic [4:0] md_cnt, md_cnt_d;

  logic ex_md;
  logic md_go;
  logic md_release;
  logic md_busy;
  logic load_use;
  logic ex_bubble;

  // Combinational control decode of the instruction sitting in ID
  always_comb begin
    // NOTE: every field gets a default before the case so no path leaves a
    // bit unassigned; a missing default here would infer a latch.
    id_word = '0;
    if (id_valid) begin
      unique case (id_opcode)
        OPCODE_R: begin
          id_word.valid    = 1'b1;
          id_word.regwrite = 1'b1;
          id_word.aluop    = ALUOP_R_I;
          id_word.muldiv   = (ENABLE_M != 0) && id_funct7_0;
        end
        OPCODE_I: begin
          id_word.valid    = 1'b1;
          id_word.regwrite = 1'b1;
          id_word.alusrc   = 1'b1;
          id_word.aluop    = ALUOP_R_I;
        end
        OPCODE_LOAD: begin
          id_word.valid    = 1'b1;
          id_word.memread  = 1'b1;
          id_word.memtoreg = 1'b1;
          id_word.alusrc   = 1'b1;
          id_word.regwrite = 1'b1;
          id_word.aluop    = ALUOP_LOAD_STORE;
        end
        OPCODE_STORE: begin
          id_word.valid    = 1'b1;
          id_word.memwrite = 1'b1;
          id_word.alusrc   = 1'b1;
          id_word.aluop    = ALUOP_LOAD_STORE;
        end
        OPCODE_BRANCH: begin
          id_word.valid  = 1'b1;
          id_word.branch = 1'b1;
          id_word.aluop  = ALUOP_BRANCH;
        end
        OPCODE_JALR: begin
          id_word.valid        = 1'b1;
          id_word.jalr_jump    = 1'b1;
          id_word.alusrc       = 1'b1;
          id_word.regwrite     = 1'b1;
          id_word.regwrite_sel = 2'b01;
          id_word.aluop        = ALUOP_JALR;
        end
        OPCODE_JAL: begin
          id_word.valid        = 1'b1;
          id_word.regwrite     = 1'b1;
          id_word.regwrite_sel = 2'b01;
          id_word.aluop        = ALUOP_OTHER;
        end
        OPCODE_LUI: begin
          id_word.valid        = 1'b1;
          id_word.regwrite     = 1'b1;
          id_word.regwrite_sel = 2'b10;
          id_word.aluop        = ALUOP_OTHER;
        end
        OPCODE_AUIPC: begin
          id_word.valid        = 1'b1;
          id_word.regwrite     = 1'b1;
          id_word.regwrite_sel = 2'b11;
          id_word.aluop        = ALUOP_OTHER;
        end
        default: id_word = '0;
      endcase
    end
  end

  assign id_rd_eff = id_word.valid ? id_rd : 5'd0;

  // Hazard detection: muldiv occupancy and load-use against the EX stage
  always_comb begin
    ex_md      = ex_q.valid && ex_q.muldiv;
    md_go      = ex_md && (state_q == IDLE) && (md_cnt == 5'd0);
    md_release = (MD_LATENCY == 1) || ((state_q == BUSY) && (md_cnt == 5'd1));
    md_busy    = ex_md && !md_release;
    load_use   = ex_q.memread && (ex_rd_q != 5'd0) &&
                 ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));
    // A redirect squashes ID; otherwise a load-use hazard leaves EX empty
    ex_bubble  = ex_redirect || (!md_busy && load_use);
  end

  // Muldiv FSM state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      state_q <= IDLE;
      md_cnt  <= 5'd0;
    end else begin
      state_q <= state_d;
      md_cnt  <= md_cnt_d;
    end
  end

  // Muldiv FSM next state: start from IDLE, count down the remaining cycles
  always_comb begin
    state_d  = state_q;
    md_cnt_d = md_cnt;
    unique case (state_q)
      IDLE: begin
        if (md_go) begin
          md_cnt_d = 5'(MD_LATENCY - 1);
          if (MD_LATENCY > 1) state_d = BUSY;
        end
      end
      BUSY: begin
        md_cnt_d = md_cnt - 5'd1;
        if (md_cnt == 5'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Muldiv FSM and hazard outputs; all quiet while reset is asserted
  always_comb begin
    md_start = !rst && md_go;
    flush_id = !rst && ex_redirect;
    stall_id = !rst && !ex_redirect && (md_busy || load_use);
  end

  // Pipeline control registers: ID/EX, EX/MEM, MEM/WB
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      ex_rd_q  <= 5'd0;
      mem_rd_q <= 5'd0;
      wb_rd_q  <= 5'd0;
    end else begin
      wb_q    <= mem_q;
      wb_rd_q <= mem_rd_q;
      if (ex_bubble) begin
        ex_q     <= '0;
        ex_rd_q  <= 5'd0;
        mem_q    <= ex_q;
        mem_rd_q <= ex_rd_q;
      end else if (md_busy) begin
        mem_q    <= '0;
        mem_rd_q <= 5'd0;
      end else begin
        ex_q     <= id_word;
        ex_rd_q  <= id_rd_eff;
        mem_q    <= ex_q;
        mem_rd_q <= ex_rd_q;
      end
    end
  end

  assign ex_ctrl  = ex_q;
  assign mem_ctrl = mem_q;
  assign wb_ctrl  = wb_q;
  assign ex_rd    = ex_rd_q;
  assign mem_rd   = mem_rd_q;
  assign wb_rd    = wb_rd_q;

endmodule

// File: tb/tb_control_pipeline.sv
// tb_control_pipeline: directed vector tables and corner sequences with
// literal expectations, then randomized traffic against a behavioural model
// that tracks per-stage words and how long the EX occupant has been there.
module tb_control_pipeline;

  localparam int L = 4;

  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_UNDEF  = 5'b11111;

  logic clk = 1'b0;
  logic rst, id_valid, id_funct7_0, ex_redirect;
  logic [4:0] id_opcode, id_rs1, id_rs2, id_rd;

  logic        stall_id, flush_id, md_start;
  logic [13:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [4:0]  ex_rd, mem_rd, wb_rd;

  logic        nom_stall_id, nom_flush_id, nom_md_start;
  logic [13:0] nom_ex_ctrl, nom_mem_ctrl, nom_wb_ctrl;
  logic [4:0]  nom_ex_rd, nom_mem_rd, nom_wb_rd;

  control_pipeline #(.ENABLE_M(1), .MD_LATENCY(L)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct7_0(id_funct7_0), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect), .stall_id(stall_id), .flush_id(flush_id),
    .md_start(md_start), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd)
  );

  control_pipeline #(.ENABLE_M(0), .MD_LATENCY(L)) dut_nom (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct7_0(id_funct7_0), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect), .stall_id(nom_stall_id), .flush_id(nom_flush_id),
    .md_start(nom_md_start), .ex_ctrl(nom_ex_ctrl), .mem_ctrl(nom_mem_ctrl),
    .wb_ctrl(nom_wb_ctrl), .ex_rd(nom_ex_rd), .mem_rd(nom_mem_rd), .wb_rd(nom_wb_rd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] ctrl;
    logic [4:0]  rd;
  } stage_t;

  typedef struct {
    logic [4:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [13:0] exp;
  } vec_t;

  stage_t m_ex, m_mem, m_wb;
  int     m_age;
  logic   m_busy, m_lu;
  int     tests = 0;
  int     fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode built field by field from the instruction-class rules
  function automatic logic [13:0] model_decode(input logic v, input logic [4:0] op,
                                               input logic f7, input bit en_m);
    logic md, jalr, rw, as, mw, m2r, mr, br, ok;
    logic [1:0] sel;
    logic [2:0] aop;
    md = 0; jalr = 0; rw = 0; as = 0; mw = 0; m2r = 0; mr = 0; br = 0; ok = 1;
    sel = 2'b00; aop = 3'b000;
    case (op)
      OP_R:      begin rw = 1; aop = 3'b010; md = en_m & f7; end
      OP_I:      begin rw = 1; as = 1; aop = 3'b010; end
      OP_LOAD:   begin mr = 1; m2r = 1; as = 1; rw = 1; aop = 3'b000; end
      OP_STORE:  begin mw = 1; as = 1; aop = 3'b000; end
      OP_BRANCH: begin br = 1; aop = 3'b001; end
      OP_JALR:   begin jalr = 1; as = 1; rw = 1; sel = 2'b01; aop = 3'b011; end
      OP_JAL:    begin rw = 1; sel = 2'b01; aop = 3'b100; end
      OP_LUI:    begin rw = 1; sel = 2'b10; aop = 3'b100; end
      OP_AUIPC:  begin rw = 1; sel = 2'b11; aop = 3'b100; end
      default:   ok = 0;
    endcase
    if (!(v && ok)) return 14'd0;
    return {md, jalr, sel, rw, as, mw, aop, m2r, mr, br, 1'b1};
  endfunction

  task automatic drive(input logic v, input logic [4:0] op, input logic f7,
                       input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd);
    id_valid = v; id_opcode = op; id_funct7_0 = f7;
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
  endtask

  task automatic drive_bubble();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  // Mid-cycle: compare every output of the main DUT with the model
  task automatic half();
    logic ex_md, e_stall, e_flush, e_start;
    @(negedge clk);
    ex_md   = m_ex.ctrl[13] & m_ex.ctrl[0];
    m_busy  = ex_md && (m_age < L - 1);
    m_lu    = m_ex.ctrl[2] && (m_ex.rd != 5'd0) &&
              ((m_ex.rd == id_rs1) || (m_ex.rd == id_rs2));
    e_flush = !rst && ex_redirect;
    e_stall = !rst && !ex_redirect && (m_busy || m_lu);
    e_start = !rst && ex_md && (m_age == 0);
    check("stall_id", stall_id, e_stall);
    check("flush_id", flush_id, e_flush);
    check("md_start", md_start, e_start);
    check("ex_ctrl", ex_ctrl, m_ex.ctrl);
    check("mem_ctrl", mem_ctrl, m_mem.ctrl);
    check("wb_ctrl", wb_ctrl, m_wb.ctrl);
    check("ex_rd", ex_rd, m_ex.rd);
    check("mem_rd", mem_rd, m_mem.rd);
    check("wb_rd", wb_rd, m_wb.rd);
  endtask

  // Clock edge: advance the model with the inputs sampled at that edge
  task automatic edge_();
    stage_t bub;
    bub = '{ctrl: 14'd0, rd: 5'd0};
    @(posedge clk);
    if (rst) begin
      m_ex = bub; m_mem = bub; m_wb = bub; m_age = 0;
    end else begin
      m_wb = m_mem;
      if (ex_redirect || (m_lu && !m_busy)) begin
        m_mem = m_ex; m_ex = bub; m_age = 0;
      end else if (m_busy) begin
        m_mem = bub; m_age++;
      end else begin
        m_mem = m_ex;
        m_ex.ctrl = model_decode(id_valid, id_opcode, id_funct7_0, 1'b1);
        m_ex.rd   = m_ex.ctrl[0] ? id_rd : 5'd0;
        m_age = 0;
      end
    end
    #1;
  endtask

  task automatic cycle();
    half();
    edge_();
  endtask

  vec_t vecs[9];
  logic [4:0] ops[11];

  initial begin
    int stall_n, start_n, bub_n, nom_stall_n, nom_start_n;

    vecs[0] = '{OP_R,      5'd1, 5'd2, 5'd1,  14'h221};
    vecs[1] = '{OP_I,      5'd1, 5'd0, 5'd2,  14'h321};
    vecs[2] = '{OP_LOAD,   5'd2, 5'd0, 5'd5,  14'h30D};
    vecs[3] = '{OP_STORE,  5'd3, 5'd4, 5'd0,  14'h181};
    vecs[4] = '{OP_BRANCH, 5'd6, 5'd7, 5'd0,  14'h013};
    vecs[5] = '{OP_JALR,   5'd9, 5'd0, 5'd8,  14'h1731};
    vecs[6] = '{OP_JAL,    5'd0, 5'd0, 5'd10, 14'h641};
    vecs[7] = '{OP_LUI,    5'd0, 5'd0, 5'd11, 14'hA41};
    vecs[8] = '{OP_AUIPC,  5'd0, 5'd0, 5'd12, 14'hE41};
    ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR,
            OP_JAL, OP_LUI, OP_AUIPC, OP_UNDEF, 5'b10101};

    // Reset from power-up X
    rst = 1'b1; ex_redirect = 1'b0; drive_bubble();
    @(posedge clk); @(posedge clk); #1;
    m_ex = '{ctrl: 14'd0, rd: 5'd0}; m_mem = m_ex; m_wb = m_ex; m_age = 0;
    rst = 1'b0;
    half();
    check("reset ctrl", {ex_ctrl, mem_ctrl, wb_ctrl}, 42'd0);
    check("reset rd", {ex_rd, mem_rd, wb_rd}, 15'd0);
    check("reset hazards", {stall_id, flush_id, md_start}, 3'b000);
    edge_();

    // Every instruction class reaches WB three cycles after ID
    for (int k = 0; k < 12; k++) begin
      if (k < 9) drive(1'b1, vecs[k].op, 1'b0, vecs[k].rs1, vecs[k].rs2, vecs[k].rd);
      else drive_bubble();
      half();
      if (k >= 3) begin
        check("class wb_ctrl", wb_ctrl, vecs[k-3].exp);
        check("class wb_rd", wb_rd, vecs[k-3].rd);
      end
      edge_();
    end

    // Load-use: LW x5 then ADD x6,x5,x1
    drive(1'b1, OP_LOAD, 1'b0, 5'd1, 5'd0, 5'd5);
    cycle();
    drive(1'b1, OP_R, 1'b0, 5'd5, 5'd1, 5'd6);
    half();
    check("lu stall", stall_id, 1'b1);
    check("lu ex is lw", ex_ctrl, 14'h30D);
    edge_();
    half();
    check("lu stall once", stall_id, 1'b0);
    check("lu ex bubble", ex_ctrl, 14'd0);
    edge_();
    drive_bubble();
    half();
    check("lu add late", ex_ctrl, 14'h221);
    check("lu add rd", ex_rd, 5'd6);
    edge_();
    cycle(); cycle();

    // MUL x7: EX occupied L cycles, L-1 held; plain R-format without M
    drive(1'b1, OP_R, 1'b1, 5'd1, 5'd2, 5'd7);
    cycle();
    drive(1'b1, OP_R, 1'b0, 5'd3, 5'd4, 5'd8);
    stall_n = 0; start_n = 0; bub_n = 0; nom_stall_n = 0; nom_start_n = 0;
    for (int j = 0; j < 5; j++) begin
      if (j == 4) drive_bubble();
      half();
      if (j < 4) begin
        stall_n += int'(stall_id); start_n += int'(md_start);
        nom_stall_n += int'(nom_stall_id); nom_start_n += int'(nom_md_start);
      end
      if (j >= 1 && j <= 3 && mem_ctrl == 14'd0) bub_n++;
      if (j == 0) begin
        check("mul ex_ctrl", ex_ctrl, 14'h2221);
        check("no-M ex_ctrl", nom_ex_ctrl, 14'h221);
      end
      if (j == 4) begin
        check("mul reaches mem", mem_ctrl, 14'h2221);
        check("after mul ex", ex_ctrl, 14'h221);
        check("after mul ex_rd", ex_rd, 5'd8);
      end
      edge_();
    end
    check("mul stall cycles", stall_n, L - 1);
    check("mul start pulses", start_n, 1);
    check("mul mem bubbles", bub_n, L - 1);
    check("no-M stall cycles", nom_stall_n, 0);
    check("no-M start pulses", nom_start_n, 0);
    cycle(); cycle();

    // Redirect coincident with a load-use condition
    drive(1'b1, OP_LOAD, 1'b0, 5'd1, 5'd0, 5'd5);
    cycle();
    drive(1'b1, OP_R, 1'b0, 5'd5, 5'd1, 5'd6);
    ex_redirect = 1'b1;
    half();
    check("redir flush", flush_id, 1'b1);
    check("redir no stall", stall_id, 1'b0);
    edge_();
    ex_redirect = 1'b0; drive_bubble();
    half();
    check("redir ex bubble", ex_ctrl, 14'd0);
    check("redir lw to mem", mem_ctrl, 14'h30D);
    edge_();

    // Undefined opcode decodes to a nop and never stalls
    drive(1'b1, OP_UNDEF, 1'b0, 5'd1, 5'd2, 5'd9);
    half();
    check("undef no stall", stall_id, 1'b0);
    edge_();
    drive_bubble();
    half();
    check("undef ex word", ex_ctrl, 14'd0);
    check("undef ex rd", ex_rd, 5'd0);
    edge_();
    cycle(); cycle();

    // Reset on the second BUSY cycle aborts the muldiv
    drive(1'b1, OP_R, 1'b1, 5'd1, 5'd2, 5'd9);
    cycle();
    drive_bubble();
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    half();
    check("rst busy ctrl", {ex_ctrl, mem_ctrl, wb_ctrl}, 42'd0);
    check("rst busy rd", {ex_rd, mem_rd, wb_rd}, 15'd0);
    check("rst busy hazards", {stall_id, flush_id, md_start}, 3'b000);
    edge_();
    start_n = 0;
    for (int j = 0; j < 6; j++) begin
      half();
      start_n += int'(md_start);
      edge_();
    end
    check("rst busy no restart", start_n, 0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom_range(0, 9) != 0), ops[$urandom_range(0, 10)], 1'($urandom),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      ex_redirect = !(m_ex.ctrl[13] && m_ex.ctrl[0]) && ($urandom_range(0, 11) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
